// File: rtl/int_ctrl.sv
// int_ctrl: eight-source interrupt controller for the SCPU INT input.
// Raw lines are synchronised and edge-detected into PEND. MASK gates PEND.
// Fixed priority (source 0 highest) selects one source for a
// request / acknowledge / service / return handshake with the CPU.
// Handshake: INT stays high in REQ until the CPU pulses int_ack for one
// cycle. The source is then in service (int_busy) until a one-cycle
// int_eret pulse. An ack outside REQ and an eret outside SVC are ignored.
module int_ctrl #(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hE000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             bus_sel,
  input  logic [31:0]      bus_addr,
  input  logic             bus_we,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             INT,
  output logic [2:0]       int_id,
  input  logic             int_ack,
  input  logic             int_eret,
  output logic             int_busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_SRC-1:0]   r_sync1;
  logic [N_SRC-1:0]   r_sync2;
  logic [N_SRC-1:0]   r_prev;
  logic [N_SRC-1:0]   r_pend;
  logic [N_SRC-1:0]   r_mask;
  logic [2:0]         r_int_id;
  logic [2:0]         w_id_nxt;
  logic [N_SRC-1:0]   w_edge;
  logic [N_SRC-1:0]   w_active;
  logic [2:0]         w_winner;
  logic               w_hit;
  logic [1:0]         w_off;
  logic               w_wr;
  logic               w_take_ack;
  logic [N_SRC-1:0]   w_set;
  logic [N_SRC-1:0]   w_clr;
  logic [N_SRC-1:0]   w_pend_nxt;
  logic               w_unused_bits;

  assign w_hit    = bus_sel && (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off    = bus_addr[3:2];
  assign w_wr     = w_hit && bus_we;
  assign w_edge   = r_sync2 & ~r_prev;
  assign w_active = r_pend & r_mask;
  assign w_unused_bits = ^{bus_addr[1:0], bus_wdata};

  // Two-flop synchroniser plus previous-value flop for rising-edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Fixed priority: the lowest active index wins
  always_comb begin
    w_winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) w_winner = 3'(i);
    end
  end

  // FSM next state; the winner is latched only when leaving IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_int_id;
    w_take_ack  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_active) begin
          w_state_nxt = S_REQ;
          w_id_nxt    = w_winner;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          w_state_nxt = S_SVC;
          w_take_ack  = 1'b1;
        end else if (!(|w_active)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SVC: begin
        if (int_eret) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pending update: a new edge wins over a same-cycle ack or W1C clear
  always_comb begin
    w_set = w_edge;
    w_clr = '0;
    if (w_wr && (w_off == 2'd3)) w_set = w_set | bus_wdata[N_SRC-1:0];
    if (w_wr && (w_off == 2'd0)) w_clr = bus_wdata[N_SRC-1:0];
    if (w_take_ack) w_clr = w_clr | (N_SRC'(1) << r_int_id);
    w_pend_nxt = (r_pend & ~w_clr) | w_set;
  end

  // State, latched id, PEND and MASK registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_int_id <= '0;
      r_pend   <= '0;
      r_mask   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_int_id <= w_id_nxt;
      r_pend   <= w_pend_nxt;
      if (w_wr && (w_off == 2'd1)) r_mask <= bus_wdata[N_SRC-1:0];
    end
  end

  // Combinational read mux; zero on miss or during a write
  always_comb begin
    bus_rdata = '0;
    if (w_hit && !bus_we) begin
      case (w_off)
        2'd0:    bus_rdata = {{(32-N_SRC){1'b0}}, r_pend};
        2'd1:    bus_rdata = {{(32-N_SRC){1'b0}}, r_mask};
        2'd2:    bus_rdata = {28'b0, int_busy, r_int_id};
        default: bus_rdata = '0;
      endcase
    end
  end

  assign INT       = (r_state == S_REQ);
  assign int_busy  = (r_state == S_SVC);
  assign int_id    = r_int_id;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed handshake scenarios followed by randomized bursts,
// checked against a queue-based model of pending / priority behaviour.
module tb_int_ctrl;

  localparam logic [31:0] BASE  = 32'hE000_0000;
  localparam logic [31:0] PEND  = BASE + 32'h0;
  localparam logic [31:0] MASK  = BASE + 32'h4;
  localparam logic [31:0] CAUSE = BASE + 32'h8;
  localparam logic [31:0] SWSET = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic        bus_sel;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        INT;
  logic [2:0]  int_id;
  logic        int_ack;
  logic        int_eret;
  logic        int_busy;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  bit auto_cpu = 1'b0;
  logic prev_int = 1'b0;

  logic [2:0]  exp_q[$];   // expected int_id for each INT assertion
  logic [31:0] rd_q[$];    // expected bus_rdata for each read cycle

  int_ctrl #(.N_SRC(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in),
    .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .INT(INT), .int_id(int_id), .int_ack(int_ack), .int_eret(int_eret),
    .int_busy(int_busy), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_sel = 1'b1; bus_addr = addr; bus_we = 1'b1; bus_wdata = data;
    tick(1);
    bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus_sel = 1'b1; bus_addr = addr; bus_we = 1'b0;
    tick(1);
    bus_sel = 1'b0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    int_eret = 1'b1; tick(1); int_eret = 1'b0;
  endtask

  // Monitor: compare each new INT request and each bus read with the queues
  always @(negedge clk) begin
    if (INT && !prev_int) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_int: got id %0d expected no request", int_id);
      end else begin
        check("int_id", {29'b0, int_id}, {29'b0, exp_q.pop_front()});
      end
    end
    prev_int <= INT;
    if (bus_sel && !bus_we) begin
      if (rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_read: got 0x%0h expected no read", bus_rdata);
      end else begin
        check("rdata", bus_rdata, rd_q.pop_front());
      end
    end else if (bus_sel && bus_we) begin
      check("rdata_on_write", bus_rdata, 32'h0);
    end
  end

  // CPU model: acknowledge each request and return after a random delay
  initial begin
    forever begin
      tick(1);
      if (auto_cpu && INT) begin
        tick($urandom_range(0, 3));
        pulse_ack();
        tick($urandom_range(0, 4));
        pulse_eret();
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] m;
    logic [7:0] bits;
    int hold;
    int c;
    reset = 1'b0; irq_in = '0; bus_sel = 1'b0; bus_addr = '0; bus_we = 1'b0;
    bus_wdata = '0; int_ack = 1'b0; int_eret = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);

    // Reset state
    check("rst_int", {31'b0, INT}, 32'h0);
    check("rst_busy", {31'b0, int_busy}, 32'h0);
    check("rst_id", {29'b0, int_id}, 32'h0);
    bus_read(PEND, 32'h0);
    bus_read(MASK, 32'h0);
    bus_read(CAUSE, 32'h0);

    // 1. Single source with three-cycle input latency
    bus_write(MASK, 32'h01);
    exp_q.push_back(3'd0);
    irq_in[0] = 1'b1;
    tick(3);
    irq_in[0] = 1'b0;
    check("t1_int_before", {31'b0, INT}, 32'h0);
    bus_read(PEND, 32'h01);
    check("t1_int", {31'b0, INT}, 32'h1);
    check("t1_id", {29'b0, int_id}, 32'h0);
    pulse_ack();
    check("t1_int_ack", {31'b0, INT}, 32'h0);
    check("t1_busy", {31'b0, int_busy}, 32'h1);
    bus_read(PEND, 32'h0);
    bus_read(CAUSE, 32'h8);
    pulse_eret();
    check("t1_busy_eret", {31'b0, int_busy}, 32'h0);
    pulse_ack();
    check("t1_ack_idle", {31'b0, int_busy}, 32'h0);

    // 2. Priority and queuing
    bus_write(MASK, 32'hFF);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd5);
    irq_in = 8'h24;
    tick(3);
    irq_in = '0;
    tick(1);
    check("t2_int", {31'b0, INT}, 32'h1);
    bus_read(CAUSE, 32'h2);
    pulse_eret();
    check("t2_eret_in_req", {31'b0, INT}, 32'h1);
    pulse_ack();
    bus_read(CAUSE, 32'hA);
    pulse_eret();
    check("t2_int_after_eret", {31'b0, INT}, 32'h0);
    tick(1);
    check("t2_int_reassert", {31'b0, INT}, 32'h1);
    bus_read(CAUSE, 32'h5);
    pulse_ack();
    bus_read(CAUSE, 32'hD);
    pulse_eret();
    bus_read(PEND, 32'h0);

    // 3. Masking
    bus_write(MASK, 32'h00);
    irq_in[3] = 1'b1;
    tick(3);
    irq_in[3] = 1'b0;
    tick(2);
    bus_read(PEND, 32'h08);
    check("t3_masked", {31'b0, INT}, 32'h0);
    exp_q.push_back(3'd3);
    bus_write(MASK, 32'h08);
    tick(1);
    check("t3_int", {31'b0, INT}, 32'h1);
    bus_write(MASK, 32'h00);
    tick(1);
    check("t3_int_drop", {31'b0, INT}, 32'h0);
    check("t3_idle", {31'b0, int_busy}, 32'h0);
    bus_write(PEND, 32'h08);

    // 4. Software set / clear and address misses
    bus_write(SWSET, 32'h81);
    exp_q.push_back(3'd7);
    bus_write(MASK, 32'h80);
    tick(1);
    check("t4_id", {29'b0, int_id}, 32'h7);
    bus_write(PEND, 32'h80);
    tick(1);
    check("t4_int_drop", {31'b0, INT}, 32'h0);
    bus_read(PEND, 32'h01);
    bus_read(SWSET, 32'h0);
    bus_read(BASE + 32'h10, 32'h0);
    bus_read(32'h0000_0000, 32'h0);
    bus_write(MASK, 32'h00);
    bus_write(PEND, 32'hFF);

    // 5. Edge coinciding with ack, then reset during service
    bus_write(MASK, 32'h02);
    exp_q.push_back(3'd1);
    irq_in[1] = 1'b1;
    tick(3);
    irq_in[1] = 1'b0;
    tick(1);
    check("t5_int", {31'b0, INT}, 32'h1);
    tick(4);
    irq_in[1] = 1'b1;
    tick(2);
    pulse_ack();
    irq_in[1] = 1'b0;
    check("t5_busy", {31'b0, int_busy}, 32'h1);
    bus_read(PEND, 32'h02);
    exp_q.push_back(3'd1);
    pulse_eret();
    tick(1);
    check("t5_reassert", {31'b0, INT}, 32'h1);
    pulse_ack();
    bus_sel = 1'b1; bus_addr = MASK; bus_we = 1'b1; bus_wdata = 32'h0;
    reset = 1'b0;
    #1;
    check("t5_rst_int", {31'b0, INT}, 32'h0);
    check("t5_rst_busy", {31'b0, int_busy}, 32'h0);
    check("t5_rst_id", {29'b0, int_id}, 32'h0);
    bus_sel = 1'b0; bus_we = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    bus_read(MASK, 32'h0);
    bus_read(PEND, 32'h0);

    // Randomized bursts: all bits rise together, service in index order
    auto_cpu = 1'b1;
    for (int r = 0; r < 25; r++) begin
      bus_write(MASK, 32'h00);
      bus_write(PEND, 32'hFF);
      m    = 8'($urandom_range(0, 255));
      bits = 8'($urandom_range(1, 255));
      bus_write(MASK, {24'b0, m});
      for (int i = 0; i < 8; i++) begin
        if (bits[i] && m[i]) exp_q.push_back(3'(i));
      end
      irq_in = bits;
      hold = $urandom_range(1, 20);
      tick(hold);
      irq_in = '0;
      c = 0;
      while (c < 600 && !(exp_q.size() == 0 && !INT && !int_busy)) begin
        tick(1);
        c++;
      end
      check("rand_timeout", {31'b0, (c >= 600)}, 32'h0);
      tick(8);
      bus_read(PEND, {24'b0, bits & ~m});
      if (c >= 600) exp_q.delete();
    end
    auto_cpu = 1'b0;
    tick(2);

    check("exp_q_empty", exp_q.size(), 32'h0);
    check("rd_q_empty", rd_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller that drives the SCPU `INT` input. It collects up to eight external interrupt sources, latches them as pending, and applies a software-programmable mask. It picks one source by fixed priority and sequences the CPU handshake: request, acknowledge, service, return. It sits on the CPU data bus beside DM, decoded at its own address window, so the handler can read the cause and clear or mask sources.

## Interface
Parameters:
- `N_SRC`, default 8: number of interrupt sources (1..8).
- `BASE_ADDR`, default 32'hE000_0000: 16-byte register window base; bits [3:0] are ignored.

Ports:
- `clk`  in  1: system clock, rising-edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `irq_in`  in  N_SRC: raw asynchronous interrupt lines, rising-edge sensitive.
- `bus_sel`  in  1: bus access cycle valid (CPU_MIO-style select).
- `bus_addr`  in  32: byte address from CPU `Addr_out`.
- `bus_we`  in  1: write strobe (CPU `mem_w`).
- `bus_wdata`  in  32: write data (CPU `Data_out`).
- `bus_rdata`  out  32: read data to CPU.
- `INT`  out  1: interrupt request to CPU.
- `int_id`  out  3: index of the requested or in-service source.
- `int_ack`  in  1: CPU took the interrupt; 1-cycle pulse.
- `int_eret`  in  1: CPU executed eret; 1-cycle pulse.
- `int_busy`  out  1: a source is in service.

## Operation
Address decode:
- Hit when `bus_sel` is 1 and `bus_addr[31:4] == BASE_ADDR[31:4]`.
- Register offset is `bus_addr[3:2]`.

Registers (bits above N_SRC read 0):
- 0x0 PEND: read returns pending bits; write-1-to-clear.
- 0x4 MASK: read/write; bit=1 enables the source. Reset value 0.
- 0x8 CAUSE: read-only; returns {28'b0, int_busy, int_id}.
- 0xC SWSET: write-1-to-set the matching PEND bits; reads 0.

Bus behaviour:
- `bus_rdata` is combinational from the decoded register on a read hit.
- `bus_rdata` is 0 when there is no hit or `bus_we` is 1.
- Writes commit on the rising edge when hit and `bus_we` are both 1.

Input path:
- Each `irq_in` bit passes through a 2-flop synchronizer, then a rising-edge detector (compares against the previous synced value).
- A detected edge sets the matching PEND bit.

Arbitration:
- Active set = PEND & MASK.
- Winner = lowest set index, so source 0 has the highest priority.

State machine:
- IDLE: `INT`=0, `int_busy`=0.
  - Active set nonzero: latch winner into `int_id` and go to REQ.
- REQ: `INT`=1.
  - `int_ack`: clear PEND[int_id] and go to SVC.
  - Active set becomes zero before ack (masked or cleared by software): go to IDLE with `INT`=0.
  - Winner is not re-evaluated while in REQ.
- SVC: `INT`=0, `int_busy`=1, `int_id` held.
  - `int_eret`: go to IDLE. Re-arbitration happens in IDLE on the next cycle.
- No nesting: new pending bits accumulate during SVC.
- `int_ack` outside REQ is ignored; `int_eret` outside SVC is ignored.

Simultaneous events:
- Edge set and clear (ack or W1C) on the same bit in the same cycle: set wins, so no edge is lost.
- SWSET and W1C cannot occur in the same cycle (one bus write per cycle).
- `int_ack` and `int_eret` in the same cycle: only the one legal for the current state takes effect.

## Timing
- Reset (asynchronous, `reset`=0):
  - State IDLE.
  - PEND, MASK, synchronizer and edge flops cleared.
  - `INT`=0, `int_id`=0, `int_busy`=0.
- Reset asserted mid-operation aborts any REQ or SVC immediately; no pending state survives.
- `irq_in` rise to PEND set: 3 rising edges (2 synchronizer + 1 edge register).
- PEND/MASK active to `INT`=1: 1 edge (IDLE to REQ).
- So `irq_in` rise to `INT` is 4 cycles worst case when enabled and IDLE.
- `int_ack` sampled high: `INT`=0 and `int_busy`=1 after that edge.
- `int_eret` sampled high: IDLE after that edge; `INT` can reassert at the earliest 1 edge later.
- A level held high on `irq_in` produces only one pending event until it falls and rises again.

## Test plan
1. Single source:
   - Stimulus: MASK=0x01, pulse `irq_in[0]`.
   - Response: PEND=0x01 after 3 clocks; `INT`=1, `int_id`=0 on the 4th.
   - Then `int_ack`: `INT`=0, `int_busy`=1, PEND=0x00. Then `int_eret`: IDLE.
2. Priority and queuing:
   - Stimulus: MASK=0xFF, `irq_in[5]` and `irq_in[2]` rise together.
   - Response: `int_id`=2 first.
   - After ack and eret, `INT` reasserts with `int_id`=5. CAUSE reads 0x5 during REQ and 0xD during SVC.
3. Masking:
   - Stimulus: MASK=0x00, pulse `irq_in[3]`.
   - Response: PEND=0x08, `INT` stays 0.
   - Write MASK=0x08: `INT`=1 one clock later. Write MASK=0x00 while in REQ: `INT`=0 next clock, state IDLE.
4. Software access:
   - Write SWSET=0x81, MASK=0x80: `int_id`=7.
   - Write PEND=0x80 (W1C) before ack: `INT` drops, PEND=0x01.
   - Reads with no address hit return 0.
5. Simultaneity and reset:
   - New `irq_in[1]` edge in the same cycle as `int_ack` for id 1: PEND[1] stays 1.
   - Assert `reset`=0 during SVC: all outputs 0 immediately, MASK=0 after release.
